mem_port_arbiter: RTL

//  Shares one single-ported memory between the core fetch port (imem*) and the load/store port (dmem*).

---
 rtl/mem_port_arbiter_pkg.sv | 10 +
 rtl/mem_port_arbiter_if.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 104 ++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state and size-code definitions for the memory port arbiter
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_RESP} arb_state_t;

    localparam logic [2:0] SZ_B = 3'b000;
    localparam logic [2:0] SZ_H = 3'b001;
    localparam logic [2:0] SZ_W = 3'b010;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - core fetch/data ports and unified memory bus seen by the arbiter
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          ifReq;
    logic [AW-1:0] ifAddr;
    logic [DW-1:0] ifRdata;
    logic          ifValid;
    logic          ifStall;
    logic          dReq;
    logic          dWen;
    logic [2:0]    dSize;
    logic [AW-1:0] dAddr;
    logic [DW-1:0] dWdata;
    logic [DW-1:0] dRdata;
    logic          dValid;
    logic          dStall;
    logic          memReq;
    logic          memWen;
    logic [2:0]    memSize;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memWdata;
    logic          memGnt;
    logic          memRvalid;
    logic [DW-1:0] memRdata;
    logic          protoErr;

    modport slave (
        input  ifReq, ifAddr, dReq, dWen, dSize, dAddr, dWdata, memGnt, memRvalid, memRdata,
        output ifRdata, ifValid, ifStall, dRdata, dValid, dStall,
        output memReq, memWen, memSize, memAddr, memWdata, protoErr
    );

    modport master (
        output ifReq, ifAddr, dReq, dWen, dSize, dAddr, dWdata, memGnt, memRvalid, memRdata,
        input  ifRdata, ifValid, ifStall, dRdata, dValid, dStall,
        input  memReq, memWen, memSize, memAddr, memWdata, protoErr
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported memory between the fetch and load/store ports
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    arb_state_t    state;
    logic          owner_d;
    logic          wen_q;
    logic [2:0]    size_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [3:0]    starve_cnt;
    logic          proto_err;
    logic          data_wins;
    logic          complete;

    assign data_wins = bus.dReq && !(bus.ifReq && (starve_cnt == STARVE_LIM));
    assign complete  = bus.memRvalid &&
                       (((state == ARB_REQ) && bus.memGnt) || (state == ARB_RESP));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB_IDLE;
            owner_d    <= 1'b0;
            wen_q      <= 1'b0;
            size_q     <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= '0;
            starve_cnt <= 4'd0;
            proto_err  <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (bus.memRvalid) begin
                        proto_err <= 1'b1;
                    end
                    if (data_wins) begin
                        state   <= ARB_REQ;
                        owner_d <= 1'b1;
                        wen_q   <= bus.dWen;
                        size_q  <= bus.dSize;
                        addr_q  <= bus.dAddr;
                        wdata_q <= bus.dWdata;
                        // Only data grants that make a waiting fetch wait longer count toward starvation
                        if (!bus.ifReq) begin
                            starve_cnt <= 4'd0;
                        end else if (starve_cnt < STARVE_LIM) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                    end else if (bus.ifReq) begin
                        state      <= ARB_REQ;
                        owner_d    <= 1'b0;
                        wen_q      <= 1'b0;
                        size_q     <= SZ_W;
                        addr_q     <= bus.ifAddr;
                        wdata_q    <= '0;
                        starve_cnt <= 4'd0;
                    end else begin
                        starve_cnt <= 4'd0;
                    end
                end
                ARB_REQ: begin
                    if (bus.memGnt) begin
                        state <= bus.memRvalid ? ARB_IDLE : ARB_RESP;
                    end else if (bus.memRvalid) begin
                        proto_err <= 1'b1;
                    end
                end
                ARB_RESP: begin
                    if (bus.memRvalid) begin
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    assign bus.memReq   = (state == ARB_REQ);
    assign bus.memWen   = wen_q;
    assign bus.memSize  = size_q;
    assign bus.memAddr  = addr_q;
    assign bus.memWdata = wdata_q;
    assign bus.protoErr = proto_err;

    // Read data is forwarded straight from memory so completion costs no extra cycle
    assign bus.ifValid  = complete && !owner_d;
    assign bus.dValid   = complete && owner_d;
    assign bus.ifRdata  = bus.memRdata;
    assign bus.dRdata   = bus.memRdata;
    assign bus.ifStall  = bus.ifReq && !bus.ifValid;
    assign bus.dStall   = bus.dReq && !bus.dValid;

endmodule
